// File: rtl/global_pkg.sv
// Types shared across the DMA subsystem.
package global_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_RX   = 2'd1,
    OWNER_TX   = 2'd2
  } owner_t;

endpackage

// File: rtl/dma_arbiter.sv
// Round-robin arbiter that shares the CPU-granted system bus between the RX and TX
// DMA engines, with a per-grant hold watchdog and completed-transfer counters.
module dma_arbiter
  import global_pkg::*;
#(
  parameter int HOLD_MAX = 32
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Rx_En,
  input  logic       Tx_En,
  output logic       Rx_Ena,
  output logic       Tx_Ena,
  input  logic       Rx_Bus_req,
  input  logic       Tx_Bus_req,
  output logic       Rx_Bus_grant,
  output logic       Tx_Bus_grant,
  input  logic       Rx_Dma_End,
  input  logic       Tx_Dma_End,
  input  logic [7:0] Rx_Address,
  input  logic [7:0] Tx_Address,
  input  logic [7:0] Rx_Databus,
  input  logic [7:0] Tx_Databus,
  input  logic       Rx_Cs,
  input  logic       Rx_Wena,
  input  logic       Tx_Cs,
  input  logic       Tx_Oen,
  output logic [7:0] Address,
  output logic [7:0] Databus,
  output logic       Cs,
  output logic       Wena,
  output logic       Oen,
  output logic       Bus_req,
  input  logic       Bus_grant,
  output logic [7:0] Rx_Count,
  output logic [7:0] Tx_Count,
  output logic       Timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_REQ = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [5:0] HOLD_LAST = 6'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  owner_t     last_served_q, last_served_d;
  logic [5:0] hold_q, hold_d;
  logic [7:0] rx_count_q, rx_count_d;
  logic [7:0] tx_count_q, tx_count_d;
  logic       suspended_q, suspended_d;

  logic own_rx, own_tx;
  logic rx_want, tx_want;
  logic own_want, own_en, own_end;
  logic timeout_c;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    hold_d        = hold_q;
    rx_count_d    = rx_count_q;
    tx_count_d    = tx_count_q;
    suspended_d   = suspended_q;
    timeout_c     = 1'b0;
    Bus_req       = 1'b0;
    Rx_Bus_grant  = 1'b0;
    Tx_Bus_grant  = 1'b0;
    Rx_Ena        = Rx_En;
    Tx_Ena        = Tx_En;
    Address       = '0;
    Databus       = '0;
    Cs            = 1'b0;
    Wena          = 1'b0;
    Oen           = 1'b0;

    own_rx   = (owner_q == OWNER_RX);
    own_tx   = (owner_q == OWNER_TX);
    rx_want  = Rx_En & Rx_Bus_req;
    tx_want  = Tx_En & Tx_Bus_req;
    own_want = (own_rx & rx_want) | (own_tx & tx_want);
    own_en   = (own_rx & Rx_En) | (own_tx & Tx_En);
    own_end  = (own_rx & Rx_Dma_End) | (own_tx & Tx_Dma_End);

    case (state_q)
      IDLE: begin
        if (rx_want && tx_want) begin
          owner_d = (last_served_q == OWNER_RX) ? OWNER_TX : OWNER_RX;
          state_d = CPU_REQ;
        end else if (rx_want) begin
          owner_d = OWNER_RX;
          state_d = CPU_REQ;
        end else if (tx_want) begin
          owner_d = OWNER_TX;
          state_d = CPU_REQ;
        end
      end

      CPU_REQ: begin
        Bus_req = 1'b1;
        // A suspended owner stays frozen until the CPU hands the bus back.
        if (suspended_q && !Bus_grant) begin
          if (own_rx) Rx_Ena = 1'b0;
          if (own_tx) Tx_Ena = 1'b0;
        end
        if (!own_want) begin
          state_d     = RELEASE;
          suspended_d = 1'b0;
        end else if (Bus_grant) begin
          state_d     = GRANT;
          hold_d      = '0;
          suspended_d = 1'b0;
        end
      end

      GRANT: begin
        Bus_req = 1'b1;
        if (!Bus_grant) begin
          if (own_rx) Rx_Ena = 1'b0;
          if (own_tx) Tx_Ena = 1'b0;
          state_d     = CPU_REQ;
          suspended_d = 1'b1;
        end else begin
          Rx_Bus_grant = own_rx;
          Tx_Bus_grant = own_tx;
          if (own_rx) begin
            Address = Rx_Address;
            Databus = Rx_Databus;
            Cs      = Rx_Cs;
            Wena    = Rx_Wena;
          end else if (own_tx) begin
            Address = Tx_Address;
            Databus = Tx_Databus;
            Cs      = Tx_Cs;
            Oen     = Tx_Oen;
          end
          // Enable loss ends the tenure silently; Dma_End beats the watchdog.
          if (!own_en) begin
            state_d       = RELEASE;
            last_served_d = owner_q;
          end else if (own_end) begin
            state_d       = RELEASE;
            last_served_d = owner_q;
            if (own_rx) rx_count_d = rx_count_q + 8'd1;
            if (own_tx) tx_count_d = tx_count_q + 8'd1;
          end else if (hold_q == HOLD_LAST) begin
            state_d       = RELEASE;
            last_served_d = owner_q;
            timeout_c     = 1'b1;
          end else begin
            hold_d = hold_q + 6'd1;
          end
        end
      end

      RELEASE: begin
        owner_d = OWNER_NONE;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign Timeout  = timeout_c & Rst_n;
  assign Rx_Count = rx_count_q;
  assign Tx_Count = tx_count_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_NONE;
      last_served_q <= OWNER_TX;
      hold_q        <= '0;
      rx_count_q    <= '0;
      tx_count_q    <= '0;
      suspended_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      hold_q        <= hold_d;
      rx_count_q    <= rx_count_d;
      tx_count_q    <= tx_count_d;
      suspended_q   <= suspended_d;
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: each bus tenure (Bus_req high run) is summarised
// by a monitor and compared against hand-computed expectations queued by the stimulus.
module tb_dma_arbiter;

  logic       Clk;
  logic       Rst_n;
  logic       Rx_En, Tx_En;
  logic       Rx_Ena, Tx_Ena;
  logic       Rx_Bus_req, Tx_Bus_req;
  logic       Rx_Bus_grant, Tx_Bus_grant;
  logic       Rx_Dma_End, Tx_Dma_End;
  logic [7:0] Rx_Address, Tx_Address, Rx_Databus, Tx_Databus;
  logic       Rx_Cs, Rx_Wena, Tx_Cs, Tx_Oen;
  logic [7:0] Address, Databus;
  logic       Cs, Wena, Oen;
  logic       Bus_req, Bus_grant;
  logic [7:0] Rx_Count, Tx_Count;
  logic       Timeout;

  dma_arbiter #(.HOLD_MAX(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Rx_En(Rx_En), .Tx_En(Tx_En), .Rx_Ena(Rx_Ena), .Tx_Ena(Tx_Ena),
    .Rx_Bus_req(Rx_Bus_req), .Tx_Bus_req(Tx_Bus_req),
    .Rx_Bus_grant(Rx_Bus_grant), .Tx_Bus_grant(Tx_Bus_grant),
    .Rx_Dma_End(Rx_Dma_End), .Tx_Dma_End(Tx_Dma_End),
    .Rx_Address(Rx_Address), .Tx_Address(Tx_Address),
    .Rx_Databus(Rx_Databus), .Tx_Databus(Tx_Databus),
    .Rx_Cs(Rx_Cs), .Rx_Wena(Rx_Wena), .Tx_Cs(Tx_Cs), .Tx_Oen(Tx_Oen),
    .Address(Address), .Databus(Databus), .Cs(Cs), .Wena(Wena), .Oen(Oen),
    .Bus_req(Bus_req), .Bus_grant(Bus_grant),
    .Rx_Count(Rx_Count), .Tx_Count(Tx_Count), .Timeout(Timeout)
  );

  typedef struct packed {
    logic [1:0]  owner;   // 0 none, 1 rx, 2 tx, 3 both
    logic [7:0]  grants;
    logic [7:0]  frozen;
    logic [7:0]  tmo;
    logic [7:0]  leak;
    logic [18:0] bus;
    logic [7:0]  rxc;
    logic [7:0]  txc;
  } txn_t;

  localparam logic [18:0] RX_BUS = {8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0};
  localparam logic [18:0] TX_BUS = {8'h5A, 8'hC3, 1'b1, 1'b0, 1'b1};

  txn_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_rx = 8'd0;
  logic [7:0] exp_tx = 8'd0;
  bit         mon_en = 1'b0;

  logic [18:0] bus_now;
  assign bus_now = {Address, Databus, Cs, Wena, Oen};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_txn(input logic [1:0] owner, input int grants, input int frozen,
                            input int tmo);
    txn_t t;
    t.owner  = owner;
    t.grants = 8'(grants);
    t.frozen = 8'(frozen);
    t.tmo    = 8'(tmo);
    t.leak   = 8'd0;
    t.bus    = (owner == 2'd1) ? RX_BUS : (owner == 2'd2) ? TX_BUS : 19'd0;
    t.rxc    = exp_rx;
    t.txc    = exp_tx;
    exp_q.push_back(t);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (Bus_req) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL bus_req_wait: Bus_req=0 after 20 cycles, required 1");
  endtask

  // CPU grants one cycle after Bus_req; the owner ends on its len-th grant cycle.
  task automatic tenure(input int ch, input int len, input bit do_end, input int stray_at);
    wait_req();
    tick();
    Bus_grant = 1'b1;
    for (int k = 1; k <= len; k++) begin
      tick();
      Rx_Dma_End = 1'b0;
      Tx_Dma_End = 1'b0;
      if (k == stray_at) begin
        if (ch == 1) Tx_Dma_End = 1'b1;
        else         Rx_Dma_End = 1'b1;
      end
      if (k == len && do_end) begin
        if (ch == 1) Rx_Dma_End = 1'b1;
        else         Tx_Dma_End = 1'b1;
      end
    end
    tick();
    Rx_Dma_End = 1'b0;
    Tx_Dma_End = 1'b0;
    Bus_grant  = 1'b0;
  endtask

  // Monitor: summarise each tenure and check quiet outputs while Bus_req is low.
  int          g_rx, g_tx, frz, tmo, leak, txn_no;
  logic [18:0] bus_seen;
  logic        prev_req;
  txn_t        got, want;

  initial begin
    prev_req = 1'b0;
    txn_no   = 0;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        if (Bus_req) begin
          if (!prev_req) begin
            g_rx = 0; g_tx = 0; frz = 0; tmo = 0; leak = 0; bus_seen = '0;
          end
          if (Rx_Bus_grant) g_rx++;
          if (Tx_Bus_grant) g_tx++;
          if (Rx_Bus_grant || Tx_Bus_grant) bus_seen = bus_now;
          else if (bus_now != 19'd0) leak++;
          if (Rx_Bus_grant && Tx_Bus_grant) leak++;
          if ((Rx_En && !Rx_Ena) || (Tx_En && !Tx_Ena)) frz++;
          if (Timeout) tmo++;
        end else begin
          n_cmp++;
          if (Rx_Bus_grant || Tx_Bus_grant || Timeout || bus_now != 19'd0 ||
              Rx_Ena != Rx_En || Tx_Ena != Tx_En) begin
            n_err++;
            $display("FAIL idle_outputs: grants=%b%b timeout=%b bus=%h ena=%b%b, required all 0 with ena=%b%b",
                     Rx_Bus_grant, Tx_Bus_grant, Timeout, bus_now, Rx_Ena, Tx_Ena, Rx_En, Tx_En);
          end
          if (prev_req) begin
            txn_no++;
            got.owner  = (g_rx > 0 && g_tx > 0) ? 2'd3 : (g_rx > 0) ? 2'd1 :
                         (g_tx > 0) ? 2'd2 : 2'd0;
            got.grants = 8'(g_rx + g_tx);
            got.frozen = 8'(frz);
            got.tmo    = 8'(tmo);
            got.leak   = 8'(leak);
            got.bus    = bus_seen;
            got.rxc    = Rx_Count;
            got.txc    = Tx_Count;
            $display("txn %0d: owner=%0d grants=%0d frozen=%0d timeout=%0d leak=%0d bus=%h rx_count=%0d tx_count=%0d",
                     txn_no, got.owner, got.grants, got.frozen, got.tmo, got.leak, got.bus,
                     got.rxc, got.txc);
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL txn%0d: unexpected tenure, owner=%0d grants=%0d, required none",
                       txn_no, got.owner, got.grants);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                n_err++;
                $display("FAIL txn%0d: got owner=%0d grants=%0d frozen=%0d timeout=%0d leak=%0d bus=%h rx=%0d tx=%0d; required owner=%0d grants=%0d frozen=%0d timeout=%0d leak=%0d bus=%h rx=%0d tx=%0d",
                         txn_no, got.owner, got.grants, got.frozen, got.tmo, got.leak, got.bus,
                         got.rxc, got.txc, want.owner, want.grants, want.frozen, want.tmo,
                         want.leak, want.bus, want.rxc, want.txc);
              end
            end
          end
        end
        prev_req = Bus_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst_n = 1'b0;
    Rx_En = 1'b1;       Tx_En = 1'b1;
    Rx_Bus_req = 1'b0;  Tx_Bus_req = 1'b0;
    Rx_Dma_End = 1'b0;  Tx_Dma_End = 1'b0;
    Bus_grant = 1'b0;
    Rx_Address = 8'hA5; Rx_Databus = 8'h3C; Rx_Cs = 1'b1; Rx_Wena = 1'b1;
    Tx_Address = 8'h5A; Tx_Databus = 8'hC3; Tx_Cs = 1'b1; Tx_Oen = 1'b1;
    repeat (3) tick();
    Rst_n = 1'b1;
    tick();

    // Reset state
    n_cmp++;
    if ({Bus_req, Rx_Bus_grant, Tx_Bus_grant, Timeout, Rx_Count, Tx_Count, bus_now,
         Rx_Ena, Tx_Ena} !== {4'b0000, 8'd0, 8'd0, 19'd0, 2'b11}) begin
      n_err++;
      $display("FAIL reset_state: req=%b grants=%b%b timeout=%b rx=%0d tx=%0d bus=%h ena=%b%b, required zeros with ena=11",
               Bus_req, Rx_Bus_grant, Tx_Bus_grant, Timeout, Rx_Count, Tx_Count, bus_now,
               Rx_Ena, Tx_Ena);
    end
    mon_en = 1'b1;

    // Both requesting from reset: RX, TX, RX
    Rx_Bus_req = 1'b1; Tx_Bus_req = 1'b1;
    exp_rx = 8'd1; expect_txn(2'd1, 4, 0, 0);
    tenure(1, 4, 1'b1, 0);
    exp_tx = 8'd1; expect_txn(2'd2, 3, 0, 0);
    tenure(2, 3, 1'b1, 0);
    exp_rx = 8'd2; expect_txn(2'd1, 5, 0, 0);
    tenure(1, 5, 1'b1, 0);
    Rx_Bus_req = 1'b0; Tx_Bus_req = 1'b0;
    repeat (2) tick();

    // RX alone, six-cycle transfer
    Rx_Bus_req = 1'b1;
    exp_rx = 8'd3; expect_txn(2'd1, 6, 0, 0);
    tenure(1, 6, 1'b1, 0);
    Rx_Bus_req = 1'b0;
    repeat (2) tick();

    // TX wins the tie after RX, runs into the watchdog; RX follows
    Rx_Bus_req = 1'b1; Tx_Bus_req = 1'b1;
    expect_txn(2'd2, 32, 0, 1);
    tenure(2, 32, 1'b0, 0);
    exp_rx = 8'd4; expect_txn(2'd1, 3, 0, 0);
    tenure(1, 3, 1'b1, 0);
    Rx_Bus_req = 1'b0; Tx_Bus_req = 1'b0;
    repeat (2) tick();

    // CPU withdraws Bus_grant for three cycles mid-transfer
    Rx_Bus_req = 1'b1;
    exp_rx = 8'd5; expect_txn(2'd1, 5, 3, 0);
    wait_req();
    tick(); Bus_grant = 1'b1;
    tick();
    tick();
    tick(); Bus_grant = 1'b0;
    tick();
    tick();
    tick(); Bus_grant = 1'b1;
    tick();
    tick();
    tick(); Rx_Dma_End = 1'b1;
    tick(); Rx_Dma_End = 1'b0; Bus_grant = 1'b0; Rx_Bus_req = 1'b0;
    repeat (2) tick();

    // Dma_End coincides with watchdog expiry
    Rx_Bus_req = 1'b1;
    exp_rx = 8'd6; expect_txn(2'd1, 32, 0, 0);
    tenure(1, 32, 1'b1, 0);
    Rx_Bus_req = 1'b0;
    repeat (2) tick();

    // Stray Tx_Dma_End while RX owns the bus
    Rx_Bus_req = 1'b1;
    exp_rx = 8'd7; expect_txn(2'd1, 4, 0, 0);
    tenure(1, 4, 1'b1, 2);
    Rx_Bus_req = 1'b0;
    repeat (2) tick();

    // Request withdrawn before the CPU grants
    Rx_Bus_req = 1'b1;
    expect_txn(2'd0, 0, 0, 0);
    wait_req();
    tick(); Rx_Bus_req = 1'b0;
    repeat (3) tick();

    // Owner enable dropped on the third grant cycle
    Rx_Bus_req = 1'b1;
    expect_txn(2'd1, 3, 0, 0);
    wait_req();
    tick(); Bus_grant = 1'b1;
    tick();
    tick();
    tick(); Rx_En = 1'b0;
    tick(); Rx_En = 1'b1; Rx_Bus_req = 1'b0; Bus_grant = 1'b0;
    repeat (2) tick();

    // Reset asserted during GRANT
    Rx_Bus_req = 1'b1;
    exp_rx = 8'd0; exp_tx = 8'd0; expect_txn(2'd1, 2, 0, 0);
    wait_req();
    tick(); Bus_grant = 1'b1;
    tick();
    tick(); Rst_n = 1'b0;
    tick(); Rst_n = 1'b1; Rx_Bus_req = 1'b0; Bus_grant = 1'b0;
    repeat (2) tick();

    // Round-robin pointer restored by reset: RX wins the tie again
    Rx_Bus_req = 1'b1; Tx_Bus_req = 1'b1;
    exp_rx = 8'd1; expect_txn(2'd1, 2, 0, 0);
    tenure(1, 2, 1'b1, 0);
    Rx_Bus_req = 1'b0; Tx_Bus_req = 1'b0;
    repeat (3) tick();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_txns: %0d expected tenures not observed, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 32, the maximum number of cycles one engine may own the bus per grant.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
  Clk  in  1  clock; all state updates on posedge Clk.
  Rst_n  in  1  reset, synchronous, active-low.
  Rx_En, Tx_En  in  1 each  channel enable from configuration register.
  Rx_Ena, Tx_Ena  out  1 each  enable to the dma_rx / dma_tx engine.
  Rx_Bus_req, Tx_Bus_req  in  1 each  engine bus request.
  Rx_Bus_grant, Tx_Bus_grant  out  1 each  engine bus grant.
  Rx_Dma_End, Tx_Dma_End  in  1 each  engine transfer-complete strobe.
  Rx_Address, Tx_Address  in  8 each  engine address.
  Rx_Databus, Tx_Databus  in  8 each  engine write data.
  Rx_Cs, Rx_Wena, Tx_Cs, Tx_Oen  in  1 each  engine RAM controls.
  Address, Databus  out  8 each  muxed system-bus address and data.
  Cs, Wena, Oen  out  1 each  muxed RAM controls.
  Bus_req  out  1  request to the CPU.
  Bus_grant  in  1  grant from the CPU.
  Rx_Count, Tx_Count  out  8 each  completed-transfer counters.
  Timeout  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-003 The block SHALL implement states IDLE, CPU_REQ, GRANT, RELEASE, plus registers owner (NONE/RX/TX) and last_served (RX/TX).
REQ-004 In IDLE, with Rx_En&Rx_Bus_req and/or Tx_En&Tx_Bus_req, the block SHALL set owner (round-robin: when both request, the channel not equal to last_served wins), assert Bus_req, and enter CPU_REQ next cycle.
REQ-005 In CPU_REQ, the block SHALL hold Bus_req=1 and enter GRANT on the first cycle Bus_grant=1.
REQ-006 In CPU_REQ, if the owner's request or enable drops, the block SHALL enter RELEASE without granting.
REQ-007 In GRANT, the block SHALL hold Bus_req=1, assert only the owner's Bus_grant, and drive Address/Databus/Cs/Wena/Oen combinationally from the owner (Oen=0 for RX, Wena=0 for TX).
REQ-008 In all other states, and for the non-owner, bus outputs SHALL be 0 and Bus_grant outputs SHALL be 0.
REQ-009 Rx_Ena SHALL equal Rx_En, and Tx_Ena SHALL equal Tx_En, except when REQ-010 forces them low.
REQ-010 In GRANT, if Bus_grant falls, the block SHALL drop the owner's Bus_grant and Ena that same cycle (freezing the engine) and return to CPU_REQ, keeping owner.
REQ-011 On owner Dma_End in GRANT, the block SHALL increment that channel's counter (mod 256), set last_served=owner, and enter RELEASE.
REQ-012 A 6-bit hold counter SHALL clear on entry to GRANT and count each GRANT cycle; when it reaches HOLD_MAX-1 without Dma_End, the block SHALL pulse Timeout, skip the counter increment, set last_served=owner, and enter RELEASE.
REQ-013 When Dma_End and watchdog expiry occur in the same cycle, Dma_End SHALL win: no Timeout, counter increments.
REQ-014 In RELEASE, the block SHALL hold Bus_req=0 and all grants 0 for exactly one cycle, clear owner, and return to IDLE.
REQ-015 The block SHALL ignore the non-owner's Dma_End.
REQ-016 Deasserting the owner's enable during GRANT SHALL behave as Dma_End without the counter increment.

Reset
REQ-017 While Rst_n=0 at posedge Clk, the block SHALL set state=IDLE, owner=NONE, last_served=TX (RX wins the first tie), hold counter=0, Rx_Count=Tx_Count=0, Timeout=0.
REQ-018 Reset mid-GRANT SHALL drop Bus_req and all grants the following cycle, with no counter update.

Structure
REQ-019 The owner_t enum (OWNER_NONE, OWNER_RX, OWNER_TX) SHALL be defined in global_pkg; the state enum and HOLD_MAX SHALL be local to the module.
REQ-020 The block SHALL be a single module with no sub-modules: one always_comb FSM/mux and one always_ff register block.

Verification
REQ-021 Rx_Bus_req alone, Bus_grant one cycle after Bus_req, Rx_Dma_End after 6 cycles: Rx_Bus_grant=1 for 6 cycles, Rx_Count=1, one RELEASE cycle with Bus_req=0.
REQ-022 Both requests held continuously after reset, three transfers: grant order RX, TX, RX; Rx_Count=2, Tx_Count=1.
REQ-023 TX owns the bus with no Dma_End and HOLD_MAX=32: Timeout pulses on the 32nd GRANT cycle, Tx_Count stays 0, and RX is granted next if requesting.
REQ-024 Bus_grant dropped for 3 cycles mid-RX transfer: Rx_Ena=0 and Rx_Bus_grant=0 for those 3 cycles, then the transfer resumes and completes with Rx_Count incremented once.
REQ-025 Rx_Dma_End on the 32nd GRANT cycle: no Timeout, Rx_Count increments.
REQ-026 Rst_n=0 during GRANT: next cycle Bus_req=0, Rx_Count=Tx_Count=0, state IDLE.
